// File: rtl/fwrisc_prefetch.sv
// Instruction prefetch buffer: fetches sequential words from fetch_pc into a DEPTH-entry FIFO.
// Latency: an entry pushed on edge N appears at out_* in cycle N+1; there is no bypass path.
// Backpressure: ivalid drops when the buffer is full or hold is set; out_ready pops the head entry.
module fwrisc_prefetch #(
  parameter int unsigned DEPTH        = 4,
  parameter logic [31:0] RESET_VECTOR = 32'h8000_0000
) (
  input  logic                      clock,
  input  logic                      reset,
  output logic [31:0]               iaddr,
  input  logic [31:0]               idata,
  output logic                      ivalid,
  input  logic                      iready,
  input  logic                      hold,
  input  logic                      redirect_valid,
  input  logic [31:0]               redirect_pc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               out_instr,
  output logic [31:0]               out_pc,
  output logic [$clog2(DEPTH):0]    count,
  output logic [31:0]               fetch_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // One buffer entry: word-aligned pc plus the fetched instruction word.
  typedef struct packed {
    logic [29:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count_q;
  logic [29:0]     fetch_pc;
  logic [31:0]     fetch_cnt_q;

  logic            full;
  logic            push;
  logic            pop;
  logic [CW-1:0]   count_nxt;
  entry_t          head;

  // Redirect target low bits are word-offset bits and carry no meaning here.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Fetch request: never depends on iready/out_ready, so a full buffer stays
  // quiet even when a pop happens in the same cycle.
  always_comb begin
    full   = (count_q == CW'(DEPTH));
    ivalid = !reset && !hold && !redirect_valid && !full;
    push   = ivalid && iready;
    pop    = !reset && !redirect_valid && out_valid && out_ready;
  end

  // Occupancy bookkeeping: simultaneous push and pop cancel out.
  always_comb begin
    count_nxt = count_q;
    case ({push, pop})
      2'b10:   count_nxt = count_q + CW'(1);
      2'b01:   count_nxt = count_q - CW'(1);
      default: count_nxt = count_q;
    endcase
  end

  // Control state: reset beats redirect, redirect beats push/pop.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      fetch_pc    <= RESET_VECTOR[31:2];
      fetch_cnt_q <= '0;
    end else if (redirect_valid) begin
      // Flush everything buffered; fetch_cnt keeps counting across redirects.
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      fetch_pc <= redirect_pc[31:2];
    end else begin
      if (push) begin
        wr_ptr      <= wr_ptr + PW'(1);
        fetch_pc    <= fetch_pc + 30'd1;
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count_q <= count_nxt;
    end
  end

  // Buffer storage: no reset needed, occupancy tracking guards every read.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= '{pc: fetch_pc, instr: idata};
    end
  end

  // Outputs are driven straight from registered state (no fetch-to-output bypass).
  always_comb begin
    head      = mem[rd_ptr];
    iaddr     = {fetch_pc, 2'b00};
    out_valid = (count_q != '0);
    out_instr = head.instr;
    out_pc    = {head.pc, 2'b00};
    count     = count_q;
    fetch_cnt = fetch_cnt_q;
  end

endmodule

// File: doc/fwrisc_prefetch.md
FWRISC_PREFETCH -- requirements
Module: fwrisc_prefetch

Interface
REQ-001 SHALL have parameter DEPTH, default 4, buffer entries; power of 2, legal range 2..16.
REQ-002 SHALL have parameter RESET_VECTOR, default 32'h8000_0000, first fetch address; bits [1:0] ignored.
REQ-003 SHALL have the ports below, in this order; CW = $clog2(DEPTH)+1:
clock  input  1  clock; all state changes on the rising edge.
reset  input  1  synchronous, active-high.
iaddr  output  32  instruction fetch address; bits [1:0] always 0.
idata  input  32  fetch data; valid in the cycle of ivalid&&iready.
ivalid  output  1  fetch request.
iready  input  1  fetch accept; data returns in the same cycle.
hold  input  1  suppresses new fetches; the buffer still drains.
redirect_valid  input  1  flushes the buffer and restarts fetch.
redirect_pc  input  32  new fetch address; bits [1:0] ignored.
out_valid  output  1  head entry available.
out_ready  input  1  consumer accepts the head entry.
out_instr  output  32  head instruction word.
out_pc  output  32  address of the head instruction.
count  output  CW  occupied entries.
fetch_cnt  output  32  accepted fetches, wrapping.

Function
REQ-004 SHALL hold a fetch_pc register and a DEPTH-entry FIFO of {pc[31:2], instr[31:0]}.
REQ-005 iaddr SHALL equal {fetch_pc[31:2], 2'b00} in every cycle.
REQ-006 ivalid SHALL be !reset && !hold && !redirect_valid && (count != DEPTH).
REQ-007 ivalid SHALL NOT depend on iready or out_ready; a full buffer with a pop in the same cycle still gives ivalid=0.
REQ-008 Push SHALL occur on ivalid&&iready: write {fetch_pc, idata} at the write pointer, advance the write pointer, fetch_pc += 1 word.
REQ-009 fetch_pc SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000 with no flag raised.
REQ-010 out_valid SHALL be (count != 0); out_instr/out_pc SHALL be the registered head entry, with out_pc[1:0]=0.
REQ-011 Pop SHALL occur on out_valid&&out_ready and advance the read pointer.
REQ-012 out_ready while out_valid=0 SHALL be ignored.
REQ-013 Latency: an entry pushed in cycle N SHALL appear at out_* in cycle N+1 at the earliest; there is no bypass.
REQ-014 Push and pop in the same cycle SHALL leave count unchanged.
REQ-015 Read and write pointers SHALL wrap modulo DEPTH.
REQ-016 While out_valid=1 and no pop, out_instr/out_pc SHALL stay stable.
REQ-017 redirect_valid SHALL take priority over push and pop: next cycle count=0 and fetch_pc={redirect_pc[31:2]}.
REQ-018 A same-cycle iready or out_ready SHALL be ignored during redirect; no push and no pop take place.
REQ-019 On redirect, the first fetch of the new stream SHALL be issued in the cycle after redirect_valid falls, unless hold is set.
REQ-020 Back-to-back redirect cycles SHALL resolve to the last redirect_pc.
REQ-021 hold=1 SHALL block pushes only; pops and redirects proceed normally.
REQ-022 fetch_cnt SHALL increment by 1 on each push and wrap at 2^32; it SHALL NOT be cleared by redirect.
REQ-023 Sustained throughput SHALL be 1 instruction/cycle when iready=1 and out_ready=1.

Reset
REQ-024 Under reset: ivalid=0, out_valid=0, count=0, fetch_cnt=0, pointers=0, fetch_pc=RESET_VECTOR[31:2].
REQ-025 Reset SHALL override redirect_valid, hold, and any in-progress push/pop; FIFO contents need not be cleared.
REQ-026 The first cycle after reset release SHALL have ivalid=1 with iaddr=RESET_VECTOR, provided hold=0.

Verification
REQ-027 Streaming: DEPTH=4, reset release, iready=1, out_ready=1, idata=addr^32'hA5A5A5A5 -> out_pc 0x80000000, 0x80000004, ... one per cycle; first out_valid 1 cycle after first push; count stays ≤1.
REQ-028 Full/backpressure: out_ready=0, iready=1 -> 4 pushes then ivalid=0, count=4, iaddr=0x80000010 held. Then out_ready=1 for one cycle -> count=3, and ivalid re-asserts the following cycle.
REQ-029 Redirect collision: count=3, redirect_pc=0x00001002 with iready=1 and out_ready=1 in the same cycle -> next cycle count=0, out_valid=0, fetch_cnt unchanged; then iaddr=0x00001000.
REQ-030 Wrap: redirect_pc=0xFFFFFFF8, stream 3 fetches -> out_pc 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
REQ-031 Hold/reset mid-operation: hold=1 with count=2 -> ivalid=0 and 2 pops drain to count=0. Assert reset with count=2 -> next cycle count=0, fetch_cnt=0, and iaddr=RESET_VECTOR after release.
